// File: rtl/rng_whiten_ctrl_pkg.sv
// Shared types and constants for the entropy whitening controller.
package rng_whiten_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int DEPTH_DEF  = 13;
  localparam int WORD_W_DEF = 8;
  localparam int DROP_W     = 8;
endpackage

// File: rtl/rng_whiten_ctrl_if.sv
// Raw-bit source and packed-word consumer signals of the whitening controller.
interface rng_whiten_ctrl_if #(parameter int WORD_W = 8);
  logic              raw_bit;
  logic              raw_valid;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (output raw_bit, raw_valid, word_ready, input word_out, word_valid);
  modport slave  (input raw_bit, raw_valid, word_ready, output word_out, word_valid);
endinterface

// File: rtl/rng_whiten_ctrl_whiten_shreg.sv
// XOR whitening shift register; o_parity is the parity of all stages as they
// will be after the current shift.
module whiten_shreg #(
  parameter int DEPTH = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_shift,
  input  logic i_bit,
  output logic o_parity
);
  logic [DEPTH-1:0] r_stages;

  always_ff @(posedge clk) begin
    if (rst_n || i_clear) r_stages <= '0;
    else if (i_shift)     r_stages <= {r_stages[DEPTH-2:0], i_bit};
  end

  // The last stage falls off on the shift, so it never contributes.
  assign o_parity = i_bit ^ (^r_stages[DEPTH-2:0]);
endmodule

// File: rtl/rng_whiten_ctrl.sv
// Whitening controller: warm-up, decimation, word packing, valid/ready hold
// and a saturating count of raw bits dropped while the consumer stalls.
//   state   | meaning
//   IDLE    | stopped, no shifting
//   WARMUP  | flushing DEPTH raw bits through the register
//   COLLECT | packing decimated whitened bits into word_out
//   HOLD    | word presented, waiting for word_ready
module rng_whiten_ctrl
  import rng_whiten_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int DECIM  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  rng_whiten_ctrl_if.slave  bus,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int WARM_W = $clog2(DEPTH + 1);
  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t              r_state, w_state_next;
  logic [WARM_W-1:0]   r_warm_cnt;
  logic [3:0]          r_decim_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [WORD_W-1:0]   r_word;
  logic                r_word_valid;
  logic                r_stop_pend;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic                w_shift, w_clear, w_take, w_last, w_hs, w_parity;

  whiten_shreg #(.DEPTH(DEPTH)) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_shift  (w_shift),
    .i_bit    (bus.raw_bit),
    .o_parity (w_parity)
  );

  assign w_hs   = r_word_valid && bus.word_ready;
  assign w_last = (r_bit_cnt == BIT_W'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = WARMUP;
        end
      end
      WARMUP: begin
        if (stop) w_state_next = IDLE;
        else if (bus.raw_valid) begin
          w_shift = 1'b1;
          if (r_warm_cnt == WARM_W'(DEPTH - 1)) w_state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (stop) w_state_next = IDLE;
        else if (bus.raw_valid) begin
          w_shift = 1'b1;
          if (r_decim_cnt == 4'(DECIM - 1)) begin
            w_take = 1'b1;
            if (w_last) w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // A stop arriving on the handshake cycle is honoured like a latched one.
        if (w_hs) w_state_next = (r_stop_pend || stop) ? IDLE : COLLECT;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_warm_cnt   <= '0;
      r_decim_cnt  <= '0;
      r_bit_cnt    <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_clear) begin
        r_warm_cnt  <= '0;
        r_decim_cnt <= '0;
        r_bit_cnt   <= '0;
        r_stop_pend <= 1'b0;
        r_drop_cnt  <= '0;
      end
      if (r_state == WARMUP && w_shift) r_warm_cnt <= r_warm_cnt + 1'b1;
      if (r_state == COLLECT && w_shift) begin
        if (w_take) begin
          r_word[r_bit_cnt] <= w_parity;
          r_bit_cnt         <= w_last ? '0 : r_bit_cnt + 1'b1;
          r_decim_cnt       <= '0;
          if (w_last) r_word_valid <= 1'b1;
        end else begin
          r_decim_cnt <= r_decim_cnt + 1'b1;
        end
      end
      if ((r_state == WARMUP || r_state == COLLECT) && stop) begin
        r_bit_cnt   <= '0;
        r_decim_cnt <= '0;
      end
      if (r_state == HOLD) begin
        if (bus.raw_valid && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
        if (stop) r_stop_pend <= 1'b1;
        if (w_hs) begin
          r_word_valid <= 1'b0;
          r_bit_cnt    <= '0;
          r_decim_cnt  <= '0;
          r_stop_pend  <= 1'b0;
        end
      end
    end
  end

  assign bus.word_out   = r_word;
  assign bus.word_valid = r_word_valid;
  assign busy           = (r_state != IDLE);
  assign drop_cnt       = r_drop_cnt;
endmodule

// File: doc/rng_whiten_ctrl.md
Name: rng_whiten_ctrl

Overview:
Controller and scheduler for the 13-stage XOR whitening shift register used to condition a raw entropy bit stream. It gates shifting to the source strobe and flushes the register after start (warm-up). It decimates the whitened bit stream, packs the bits into words and presents them on a valid/ready interface. The block sits between the raw entropy source and the downstream random-word consumer, and counts entropy lost to backpressure.

Parameters:
DEPTH, 13, number of whitening register stages; also the warm-up length in accepted shifts
WORD_W, 8, output word width in bits
DECIM, 1, keep every DECIM-th whitened bit (legal range 1..15)

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst_n  in  1  reset: synchronous, active-high (1 clears the block on the next rising clk edge)
raw_bit  in  1  raw entropy bit, qualified by raw_valid
raw_valid  in  1  raw_bit is valid this cycle; no backpressure to the source
start  in  1  single-cycle pulse: begin warm-up and collection
stop  in  1  single-cycle pulse: return to IDLE
word_out  out  WORD_W  packed whitened word, LSB = first collected bit
word_valid  out  1  word_out is valid
word_ready  in  1  consumer accepts word_out when word_valid is also 1
busy  out  1  state != IDLE
drop_cnt  out  8  saturating count of raw bits discarded in HOLD

Behaviour:
- Reset: state IDLE, all register stages 0, bit/decim/warm counters 0, word_out 0, word_valid 0, drop_cnt 0. Reset overrides every other input, including in mid-HOLD.
- Shift event: raw_valid=1 in WARMUP or COLLECT. It shifts raw_bit into stage 1 and moves stage k to stage k+1. No shift occurs in IDLE or HOLD.
- Whitened bit: parity of all DEPTH stages after the shift, i.e. raw_bit XOR stages 1..DEPTH-1 before the shift. It is captured in the same cycle as the shift.
- IDLE: on start, clear all stages, warm counter and drop_cnt, then go to WARMUP. stop in IDLE is ignored; start wins if start and stop arrive together.
- WARMUP: each shift event increments the warm counter. The DEPTH-th shift event goes to COLLECT, and its whitened bit is not collected.
- COLLECT: each shift event advances the decim counter (0..DECIM-1). When the counter is DECIM-1:
  - write the whitened bit to word_out[bitcnt];
  - increment bitcnt and reset the decim counter to 0.
  - The write of bit WORD_W-1 sets word_valid=1 from the next cycle and goes to HOLD.
- HOLD: word_out and word_valid are stable and no shift occurs. Each raw_valid increments drop_cnt, which saturates at 255. When word_valid && word_ready: clear word_valid, bitcnt and the decim counter, then return to COLLECT. No re-warm-up is needed.
- stop in WARMUP or COLLECT: go to IDLE next cycle and discard the partial word. word_valid stays 0.
- stop in HOLD: latch a pending-stop flag and keep presenting the word. After the handshake completes, go to IDLE instead of COLLECT.
- start outside IDLE is ignored.
- Latency: in steady state with DECIM=1, a word is presented one cycle after the WORD_W-th qualifying shift event.
- drop_cnt holds its value in IDLE and clears only on reset or on an accepted start.

Decomposition:
- Shared package:
  - state enum {IDLE, WARMUP, COLLECT, HOLD} (2 bits);
  - default DEPTH=13 and WORD_W=8 constants;
  - DROP_W=8.
- One natural sub-module, whiten_shreg:
  - DEPTH-stage shift register with shift enable and synchronous clear;
  - outputs the parity of stages after the shift.
- The controller FSM, counters, packer and handshake stay in rng_whiten_ctrl.

Test Plan:
1. Warm-up with all ones (DEPTH=13, WORD_W=8, DECIM=1): after start, drive raw_bit=1 with raw_valid=1 for 13 cycles -> word_valid stays 0 and state reaches COLLECT after the 13th. A further 8 ones -> word_out=0xFF with word_valid=1.
2. Parity alternation: after the warm-up of 13 ones, drive 8 zeros -> word_out=0xAA (collected bits 0,1,0,1,0,1,0,1 in LSB-first order).
3. Backpressure: hold word_ready=0 in HOLD and pulse raw_valid 5 times -> drop_cnt=5 and word_out unchanged. Then set word_ready=1 -> word_valid drops next cycle and state is COLLECT.
4. Stop mid-word: stop after 3 collected bits -> IDLE next cycle, busy=0, no word_valid. A new start requires 13 warm-up shifts again.
5. Decimation (DECIM=3): after warm-up with ones, 23 qualifying ones -> word_valid=0; the 24th -> word_out=0xFF. Gaps in raw_valid do not advance any counter.
6. Stop and reset in HOLD: stop in HOLD -> word still presented; after the handshake -> IDLE, not COLLECT. Separately, rst_n=1 in HOLD with drop_cnt=3 -> next cycle word_valid=0, drop_cnt=0, busy=0.
